// File: rtl/mem_bus_adapter.sv
// rtl/mem_bus_adapter.sv - CPU load/store request to Avalon-MM master adapter
module mem_bus_adapter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Abort fires on the stall edge that brings the count to TIMEOUT.
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  stall_cnt;
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [1:0]  cap_lane;

    logic        req_illegal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);

    always_comb begin
        req_illegal = 1'b0;
        be_next     = 4'b1111;
        wdata_next  = req_wdata;
        case (req_size)
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next     = 4'b0011 << req_addr[1:0];
                wdata_next  = {2{req_wdata[15:0]}};
                req_illegal = req_addr[0];
            end
            2'b10:   req_illegal = (req_addr[1:0] != 2'b00);
            default: req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        lane_byte = readdata[7:0];
        lane_half = readdata[15:0];
        case (cap_lane)
            2'b01: lane_byte = readdata[15:8];
            2'b10: begin
                lane_byte = readdata[23:16];
                lane_half = readdata[31:16];
            end
            2'b11: lane_byte = readdata[31:24];
            default: ;
        endcase
        case (cap_size)
            2'b00:   load_data = {{24{cap_signed & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{cap_signed & lane_half[15]}}, lane_half};
            default: load_data = readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stall_cnt  <= 8'd0;
            cap_size   <= 2'b00;
            cap_signed <= 1'b0;
            cap_lane   <= 2'b00;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
            address    <= 32'd0;
            byteenable <= 4'd0;
            writedata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_size   <= req_size;
                        cap_signed <= req_signed;
                        cap_lane   <= req_addr[1:0];
                        address    <= {req_addr[31:2], 2'b00};
                        byteenable <= be_next;
                        writedata  <= wdata_next;
                        stall_cnt  <= 8'd0;
                        resp_rdata <= 32'd0;
                        if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else begin
                            state <= BUS;
                            read  <= ~req_write;
                            write <= req_write;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= write ? 32'd0 : load_data;
                    end else if (stall_cnt == STALL_LIMIT) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb/tb_mem_bus_adapter.sv - table-driven scoreboard bench for mem_bus_adapter
module tb_mem_bus_adapter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    always #5 clk = ~clk;

    mem_bus_adapter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] wlanes;
        logic        err;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                                input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] baddr,
                                input logic [31:0] wlanes, input logic err, input logic [31:0] exp_rdata,
                                input int lat);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.rdata = rdata; v.be = be; v.baddr = baddr; v.wlanes = wlanes;
        v.err = err; v.exp_rdata = exp_rdata; v.lat = lat;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          strobes;
        logic        stable;
        logic        kind_ok;
        logic        done;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] mask;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check32({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; readdata = v.rdata; waitrequest = 1'b0;
        e.err = v.err; e.rdata = v.exp_rdata; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        cyc = 0; strobes = 0; stable = 1'b1; kind_ok = 1'b1; done = 1'b0;
        a0 = 32'd0; be0 = 4'd0; wd0 = 32'd0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (read || write) begin
                if (strobes == 0) begin
                    a0 = address; be0 = byteenable; wd0 = writedata;
                end else if (address !== a0 || byteenable !== be0 || writedata !== wd0) begin
                    stable = 1'b0;
                end
                if ((read && write) || (write !== v.wr)) kind_ok = 1'b0;
                strobes++;
            end
            waitrequest = (strobes > 0) && (strobes <= v.waits);
            if (resp_valid) done = 1'b1;
        end
        waitrequest = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_resp_timeout actual=no_resp required=resp_valid", tag);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            got = sb.pop_front();
            check32({tag, "_strobes"}, 32'(strobes), 32'(v.lat - 1));
            if (v.lat > 1) begin
                check32({tag, "_kind"}, 32'(kind_ok), 32'd1);
                check32({tag, "_addr"}, a0, v.baddr);
                check32({tag, "_be"}, 32'(be0), 32'(v.be));
                check32({tag, "_stable"}, 32'(stable), 32'd1);
                if (v.wr) begin
                    mask = {{8{be0[3]}}, {8{be0[2]}}, {8{be0[1]}}, {8{be0[0]}}};
                    check32({tag, "_wdata"}, wd0 & mask, v.wlanes);
                end
            end
            check32({tag, "_err"}, 32'(resp_error), 32'(got.err));
            check32({tag, "_rdata"}, resp_rdata, got.rdata);
            check32({tag, "_latency"}, 32'(cyc), 32'(got.lat));
            @(negedge clk);
            check32({tag, "_pulse"}, 32'(resp_valid), 32'd0);
            check32({tag, "_idle"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic quiet;
        vecs[0]  = mk(0, 2'b10, 0, 32'h10, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h10, 0, 0, 32'hDEADBEEF, 2);
        vecs[1]  = mk(0, 2'b00, 1, 32'h13, 0, 0, 32'h80FF1234, 4'b1000, 32'h10, 0, 0, 32'hFFFFFF80, 2);
        vecs[2]  = mk(0, 2'b00, 0, 32'h13, 0, 0, 32'h80FF1234, 4'b1000, 32'h10, 0, 0, 32'h00000080, 2);
        vecs[3]  = mk(1, 2'b01, 0, 32'h22, 32'h0000ABCD, 0, 32'h11111111, 4'b1100, 32'h20, 32'hABCD0000, 0, 0, 2);
        vecs[4]  = mk(0, 2'b10, 0, 32'h05, 0, 0, 32'h22222222, 0, 0, 0, 1, 0, 1);
        vecs[5]  = mk(0, 2'b10, 0, 32'h40, 0, 3, 32'h12345678, 4'b1111, 32'h40, 0, 0, 32'h12345678, 5);
        vecs[6]  = mk(0, 2'b10, 0, 32'h44, 0, 10, 32'hAAAA5555, 4'b1111, 32'h44, 0, 1, 0, TIMEOUT + 1);
        vecs[7]  = mk(0, 2'b11, 0, 32'h48, 0, 0, 32'h33333333, 0, 0, 0, 1, 0, 1);
        vecs[8]  = mk(0, 2'b01, 0, 32'h01, 0, 0, 32'h44444444, 0, 0, 0, 1, 0, 1);
        vecs[9]  = mk(0, 2'b01, 1, 32'h02, 0, 0, 32'h80017FFF, 4'b1100, 32'h00, 0, 0, 32'hFFFF8001, 2);
        vecs[10] = mk(0, 2'b01, 1, 32'h00, 0, 0, 32'h8001F00F, 4'b0011, 32'h00, 0, 0, 32'hFFFFF00F, 2);
        vecs[11] = mk(1, 2'b00, 0, 32'h31, 32'h123456A5, 0, 32'h55555555, 4'b0010, 32'h30, 32'h0000A500, 0, 0, 2);
        vecs[12] = mk(1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 1, 32'h66666666, 4'b1111, 32'h08, 32'hCAFEF00D, 0, 0, 3);
        vecs[13] = mk(0, 2'b00, 1, 32'h11, 0, 0, 32'h00007F00, 4'b0010, 32'h10, 0, 0, 32'h0000007F, 2);
        vecs[14] = mk(0, 2'b01, 0, 32'h02, 0, 2, 32'h80010000, 4'b1100, 32'h00, 0, 0, 32'h00008001, 4);
        vecs[15] = mk(1, 2'b00, 0, 32'h07, 32'h000000FF, 20, 32'h77777777, 4'b1000, 32'h04, 32'hFF000000, 1, 0, TIMEOUT + 1);

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; waitrequest = 1'b0; readdata = 32'd0;
        repeat (2) @(negedge clk);
        check32("rst_ready", 32'(req_ready), 32'd1);
        check32("rst_strobes", {30'd0, read, write}, 32'd0);
        check32("rst_resp", {30'd0, resp_valid, resp_error}, 32'd0);
        check32("rst_rdata", resp_rdata, 32'd0);
        check32("rst_addr", address, 32'd0);
        check32("rst_be_wdata", writedata | 32'(byteenable), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a stalled store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h100;
        req_wdata = 32'h00000055; waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check32("rstmid_write_on", 32'(write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check32("rstmid_write_drop", 32'(write), 32'd0);
        check32("rstmid_no_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || write || read) quiet = 1'b0;
        end
        check32("rstmid_quiet", 32'(quiet), 32'd1);
        check32("rstmid_ready", 32'(req_ready), 32'd1);
        waitrequest = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
